// File: rtl/tdm_demux1b1to4.sv
// tdm_demux1b1to4: receive end of a 1-bit 4-slot TDM link.
// Tracks the slot index against a frame sync and presents completed frames as a..d.
module tdm_demux1b1to4 #(
    parameter bit RESYNC     = 1'b1,
    parameter int MISS_LIMIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sync,
    input  logic       din,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic [1:0] slot,
    output logic       locked,
    output logic       frame_valid,
    output logic       sync_err
);
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t     r_state, w_state_nx;
    logic [1:0] r_slot, w_slot_nx;
    logic [2:0] r_h, w_h_nx;
    logic [3:0] r_miss, w_miss_nx, w_miss_inc;
    logic [3:0] r_out, w_out_nx;
    logic       r_fv, w_fv_nx, r_se, w_se_nx;
    assign w_miss_inc = r_miss + 4'd1;
    always_comb begin
        w_state_nx = r_state;
        w_slot_nx  = r_slot;
        w_h_nx     = r_h;
        w_miss_nx  = r_miss;
        w_out_nx   = r_out;
        w_fv_nx    = 1'b0;
        w_se_nx    = 1'b0;
        if (en) begin
            if (r_state == HUNT) begin
                if (sync) begin
                    w_h_nx[0]  = din;
                    w_slot_nx  = 2'd1;
                    w_miss_nx  = 4'd0;
                    w_state_nx = LOCKED;
                end
            end else if (r_slot == 2'd0) begin
                if (sync) begin
                    w_h_nx[0] = din;
                    w_slot_nx = 2'd1;
                    w_miss_nx = 4'd0;
                end else begin
                    w_se_nx   = 1'b1;
                    w_miss_nx = w_miss_inc;
                    // Too many consecutive misses: drop the sample and hunt again
                    if (w_miss_inc == 4'(MISS_LIMIT)) begin
                        w_state_nx = HUNT;
                        w_slot_nx  = 2'd0;
                    end else begin
                        w_h_nx[0] = din;
                        w_slot_nx = 2'd1;
                    end
                end
            end else if (sync && RESYNC) begin
                w_se_nx   = 1'b1;
                w_h_nx[0] = din;
                w_slot_nx = 2'd1;
                w_miss_nx = 4'd0;
            end else begin
                w_se_nx = sync;
                if (r_slot == 2'd3) begin
                    w_out_nx  = {r_h[0], r_h[1], r_h[2], din};
                    w_fv_nx   = 1'b1;
                    w_slot_nx = 2'd0;
                end else begin
                    w_h_nx[r_slot] = din;
                    w_slot_nx      = r_slot + 2'd1;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HUNT;
            r_slot  <= 2'd0;
            r_h     <= 3'd0;
            r_miss  <= 4'd0;
            r_out   <= 4'd0;
            r_fv    <= 1'b0;
            r_se    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_slot  <= w_slot_nx;
            r_h     <= w_h_nx;
            r_miss  <= w_miss_nx;
            r_out   <= w_out_nx;
            r_fv    <= w_fv_nx;
            r_se    <= w_se_nx;
        end
    end
    assign {a, b, c, d} = r_out;
    assign slot        = r_slot;
    assign locked      = (r_state == LOCKED);
    assign frame_valid = r_fv;
    assign sync_err    = r_se;
endmodule

// File: tb/tb_tdm_demux1b1to4.sv
// tb_tdm_demux1b1to4: scenario tasks plus a frame scoreboard for tdm_demux1b1to4.
module tb_tdm_demux1b1to4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, sync = 1'b0, din = 1'b0;
    logic       a, b, c, d, locked, frame_valid, sync_err;
    logic [1:0] slot;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    tdm_demux1b1to4 dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .din(din),
        .a(a), .b(b), .c(c), .d(d), .slot(slot), .locked(locked),
        .frame_valid(frame_valid), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Every frame_valid must match the oldest frame the stimulus expects
    always @(negedge clk) begin
        if (frame_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_frame: got abcd=%b, none expected", {a, b, c, d});
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if ({a, b, c, d} !== e) begin
                    errors++;
                    $display("FAIL sb_frame: got abcd=%b, expected %b", {a, b, c, d}, e);
                end
            end
        end
    end

    task automatic step(input logic e, input logic s, input logic x);
        en = e; sync = s; din = x;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(1, 0, 0);
        step(1, 0, 0);
        checks++;
        if ({a, b, c, d, slot, locked, frame_valid, sync_err} !== 9'b0) begin
            errors++;
            $display("FAIL reset: got abcd=%b slot=%0d lk=%b fv=%b se=%b, expected all 0",
                     {a, b, c, d}, slot, locked, frame_valid, sync_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_lock;
        logic [1:0] exp_slot[3] = '{2'd1, 2'd2, 2'd3};
        logic       dat[3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(1, i == 0, dat[i]);
            checks++;
            if (slot !== exp_slot[i] || locked !== 1'b1) begin
                errors++;
                $display("FAIL lock_slot%0d: got slot=%0d lk=%b, expected slot=%0d lk=1", i, slot, locked, exp_slot[i]);
            end
        end
        exp_q.push_back(4'b0101);
        step(1, 0, 1);
        checks++;
        if (slot !== 2'd0 || frame_valid !== 1'b1 || {a, b, c, d} !== 4'b0101 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL lock_frame: got slot=%0d fv=%b abcd=%b se=%b, expected 0 1 0101 0", slot, frame_valid, {a, b, c, d}, sync_err);
        end
        step(0, 1, 1);
        checks++;
        if (frame_valid !== 1'b0 || {a, b, c, d} !== 4'b0101 || slot !== 2'd0) begin
            errors++;
            $display("FAIL lock_fv_pulse: got fv=%b abcd=%b slot=%0d, expected 0 0101 0", frame_valid, {a, b, c, d}, slot);
        end
    endtask

    task automatic test_en_gap;
        step(1, 1, 0);
        step(1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, i[0], 1);
            checks++;
            if (slot !== 2'd2 || sync_err !== 1'b0 || frame_valid !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold%0d: got slot=%0d se=%b fv=%b, expected 2 0 0", i, slot, sync_err, frame_valid);
            end
        end
        step(1, 0, 0);
        exp_q.push_back(4'b0101);
        step(1, 0, 1);
        checks++;
        if (frame_valid !== 1'b1 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL gap_frame: got fv=%b se=%b, expected 1 0", frame_valid, sync_err);
        end
    endtask

    task automatic test_early_sync;
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 1);
        checks++;
        if (sync_err !== 1'b1 || slot !== 2'd1 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_sync: got se=%b slot=%0d fv=%b, expected 1 1 0", sync_err, slot, frame_valid);
        end
        step(1, 0, 1);
        step(1, 0, 1);
        exp_q.push_back(4'b1111);
        step(1, 0, 1);
        checks++;
        if (frame_valid !== 1'b1 || {a, b, c, d} !== 4'b1111 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL resync_frame: got fv=%b abcd=%b se=%b, expected 1 1111 0", frame_valid, {a, b, c, d}, sync_err);
        end
    endtask

    task automatic test_missing_sync;
        step(1, 0, 1);
        checks++;
        if (sync_err !== 1'b1 || locked !== 1'b1 || slot !== 2'd1) begin
            errors++;
            $display("FAIL miss1: got se=%b lk=%b slot=%0d, expected 1 1 1", sync_err, locked, slot);
        end
        step(1, 0, 0);
        step(1, 0, 1);
        exp_q.push_back(4'b1010);
        step(1, 0, 0);
        checks++;
        if (frame_valid !== 1'b1 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL miss1_frame: got fv=%b se=%b, expected 1 0", frame_valid, sync_err);
        end
        step(1, 0, 1);
        checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 2'd0 || {a, b, c, d} !== 4'b1010 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL miss2: got se=%b lk=%b slot=%0d abcd=%b fv=%b, expected 1 0 0 1010 0",
                     sync_err, locked, slot, {a, b, c, d}, frame_valid);
        end
    endtask

    task automatic test_hunt_ignores;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1);
            checks++;
            if (slot !== 2'd0 || locked !== 1'b0 || frame_valid !== 1'b0 || sync_err !== 1'b0 || {a, b, c, d} !== 4'b1010) begin
                errors++;
                $display("FAIL hunt%0d: got slot=%0d lk=%b fv=%b se=%b abcd=%b, expected 0 0 0 0 1010",
                         i, slot, locked, frame_valid, sync_err, {a, b, c, d});
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 4; f++) begin
            logic [3:0] v;
            v = 4'($urandom_range(0, 15));
            step(1, 1, v[3]);
            step(1, 0, v[2]);
            step(1, 0, v[1]);
            exp_q.push_back(v);
            step(1, 0, v[0]);
            checks++;
            if (frame_valid !== 1'b1 || locked !== 1'b1 || sync_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b%0d: got fv=%b lk=%b se=%b, expected 1 1 0", f, frame_valid, locked, sync_err);
            end
        end
    endtask

    task automatic test_mid_reset;
        step(1, 1, 0);
        step(1, 0, 1);
        rst = 1'b1;
        step(1, 0, 1);
        rst = 1'b0;
        checks++;
        if ({a, b, c, d} !== 4'b0000 || slot !== 2'd0 || locked !== 1'b0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got abcd=%b slot=%0d lk=%b fv=%b, expected 0000 0 0 0", {a, b, c, d}, slot, locked, frame_valid);
        end
    endtask

    initial begin
        test_reset();
        test_hunt_ignores_pre();
        test_lock();
        test_en_gap();
        test_early_sync();
        test_missing_sync();
        test_hunt_ignores();
        test_back_to_back();
        test_mid_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d frames outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic test_hunt_ignores_pre;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1);
            checks++;
            if (slot !== 2'd0 || locked !== 1'b0 || frame_valid !== 1'b0 || sync_err !== 1'b0) begin
                errors++;
                $display("FAIL hunt_pre%0d: got slot=%0d lk=%b fv=%b se=%b, expected 0 0 0 0", i, slot, locked, frame_valid, sync_err);
            end
        end
    endtask
endmodule
